axi_lite_arbiter: RTL and testbench

- Two-master, one-slave AXI-lite-style arbiter that lets the core share a single unified memory.
- Sits directly downstream of the fetch unit (master 0, read-only) and the load/store unit (master 1, read and write).
- Drives one shared sram port, using the same valid/ready channels and 3-bit resp encoding as the core.
- One transaction outstanding at a time; round-robin grant between masters.

---
 rtl/axi_arb_pkg.sv | 31 +++
 rtl/axi_arb_timer.sv | 41 ++++
 rtl/axi_lite_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
`default_nettype none
// =============================================================================
// axi_arb_pkg : state, grant and response encodings for axi_lite_arbiter
// Optional: AXI_ARB_TIMEOUT_EN adds the DRAIN state.    Revision: 1.0
// =============================================================================
package axi_arb_pkg;

`ifdef AXI_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_M0 = 3'd1,
        RD_M1 = 3'd2,
        WR_M1 = 3'd3,
        DRAIN = 3'd4
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_M0 = 2'd1,
        RD_M1 = 2'd2,
        WR_M1 = 2'd3
    } arb_state_t;
`endif

    localparam logic       GNT_M0      = 1'b0;
    localparam logic       GNT_M1      = 1'b1;
    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_DECERR = 3'b011;

endpackage
`default_nettype wire

// File: rtl/axi_arb_timer.sv
`default_nettype none
// =============================================================================
// axi_arb_timer : response timeout counter; expired stays high until cleared
// Revision: 1.0
// =============================================================================
module axi_arb_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int c_cnt_w = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYC - 1);

    logic               r_run;
    logic [c_cnt_w-1:0] r_cnt;

    // Counting from zero on the cycle after start puts expiry TIMEOUT_CYC cycles after start
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (clear) begin
            r_run <= 1'b0;
            r_cnt <= '0;
        end else if (start) begin
            r_run <= 1'b1;
            r_cnt <= '0;
        end else if (r_run && !expired) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign expired = r_run && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// =============================================================================
// axi_lite_arbiter : 2-master / 1-slave round-robin AXI-lite arbiter, one
// transaction outstanding. Optional: AXI_ARB_TIMEOUT_EN.     Revision: 1.0
// =============================================================================
module axi_lite_arbiter
    import axi_arb_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int STROB_LEN   = DATA_LEN / 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    // master 0 : fetch (read only)
    input  logic                 m0_arvalid,
    input  logic                 m0_rready,
    input  logic [ADDR_LEN-1:0]  m0_raddr,
    output logic                 m0_arready,
    output logic                 m0_rvalid,
    output logic [DATA_LEN-1:0]  m0_rdata,
    output logic [2:0]           m0_rresp,
    // master 1 : load/store
    input  logic                 m1_arvalid,
    input  logic                 m1_awvalid,
    input  logic                 m1_wvalid,
    input  logic                 m1_rready,
    input  logic                 m1_bready,
    input  logic [ADDR_LEN-1:0]  m1_raddr,
    input  logic [ADDR_LEN-1:0]  m1_waddr,
    input  logic [DATA_LEN-1:0]  m1_wdata,
    input  logic [STROB_LEN-1:0] m1_wstrob,
    output logic                 m1_arready,
    output logic                 m1_awready,
    output logic                 m1_wready,
    output logic                 m1_rvalid,
    output logic                 m1_bvalid,
    output logic [DATA_LEN-1:0]  m1_rdata,
    output logic [2:0]           m1_rresp,
    output logic [2:0]           m1_bresp,
    // shared slave
    output logic                 s_arvalid,
    output logic                 s_awvalid,
    output logic                 s_wvalid,
    output logic                 s_rready,
    output logic                 s_bready,
    output logic [ADDR_LEN-1:0]  s_raddr,
    output logic [ADDR_LEN-1:0]  s_waddr,
    output logic [DATA_LEN-1:0]  s_wdata,
    output logic [STROB_LEN-1:0] s_wstrob,
    input  logic                 s_arready,
    input  logic                 s_awready,
    input  logic                 s_wready,
    input  logic                 s_rvalid,
    input  logic                 s_bvalid,
    input  logic [DATA_LEN-1:0]  s_rdata,
    input  logic [2:0]           s_rresp,
    input  logic [2:0]           s_bresp
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       r_ar_done;
    logic       r_aw_done;
    logic       r_w_done;

    logic w_rd_m1, w_rd, w_wr;
    logic w_m0_req, w_m1_req;
    logic w_arvalid_sel, w_rready_sel, w_resp_ready;
    logic w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;
    logic w_to_active, w_to_acc;

    assign w_rd_m1 = (r_state == RD_M1);
    assign w_rd    = (r_state == RD_M0) || w_rd_m1;
    assign w_wr    = (r_state == WR_M1);

    assign w_m0_req = m0_arvalid;
    assign w_m1_req = m1_awvalid | m1_arvalid;

    assign w_arvalid_sel = w_rd_m1 ? m1_arvalid : m0_arvalid;
    assign w_rready_sel  = w_rd_m1 ? m1_rready  : m0_rready;
    assign w_resp_ready  = w_rd ? w_rready_sel : m1_bready;

    assign w_ar_hs = w_rd && w_arvalid_sel && !r_ar_done && s_arready;
    assign w_aw_hs = w_wr && m1_awvalid && !r_aw_done && s_awready;
    assign w_w_hs  = w_wr && m1_wvalid  && !r_w_done  && s_wready;
    assign w_r_hs  = w_rd && s_rvalid && w_rready_sel && !w_to_active;
    assign w_b_hs  = w_wr && s_bvalid && m1_bready    && !w_to_active;
    assign w_to_acc = w_to_active && w_resp_ready;

`ifdef AXI_ARB_TIMEOUT_EN
    logic w_expired;
    logic w_wr_start;
    logic w_slave_resp;
    logic r_to_hold;

    assign w_wr_start = w_wr && !(r_aw_done && r_w_done)
                        && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_slave_resp = w_rd ? s_rvalid : s_bvalid;
    // A slave response arriving in the expiry cycle is forwarded instead of the error
    assign w_to_active = (w_rd || w_wr) && (r_to_hold || (w_expired && !w_slave_resp));

    axi_arb_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (w_ar_hs || w_wr_start),
        .clear     (!(w_rd || w_wr)),
        .expired   (w_expired)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_to_hold <= 1'b0;
        end else begin
            r_to_hold <= w_to_active && !w_resp_ready;
        end
    end
`else
    logic w_unused_timeout;

    assign w_to_active      = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= GNT_M1;
            r_ar_done    <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                r_ar_done <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                if (w_state_nxt != IDLE) begin
                    r_last_grant <= (w_state_nxt == RD_M0) ? GNT_M0 : GNT_M1;
                end
            end else begin
                if (w_ar_hs) r_ar_done <= 1'b1;
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        m0_arready  = 1'b0;
        m0_rvalid   = 1'b0;
        m1_arready  = 1'b0;
        m1_awready  = 1'b0;
        m1_wready   = 1'b0;
        m1_rvalid   = 1'b0;
        m1_bvalid   = 1'b0;
        s_arvalid   = 1'b0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_rready    = 1'b0;
        s_bready    = 1'b0;
        case (r_state)
            IDLE: begin
                // Ties go to whichever master was not granted last
                if (w_m0_req && (!w_m1_req || r_last_grant == GNT_M1)) begin
                    w_state_nxt = RD_M0;
                end else if (w_m1_req) begin
                    w_state_nxt = m1_awvalid ? WR_M1 : RD_M1;
                end
            end
            RD_M0: begin
                s_arvalid  = m0_arvalid && !r_ar_done;
                m0_arready = s_arready && !r_ar_done;
                m0_rvalid  = s_rvalid || w_to_active;
                s_rready   = m0_rready && !w_to_active;
                if (w_r_hs) w_state_nxt = IDLE;
`ifdef AXI_ARB_TIMEOUT_EN
                if (w_to_acc) w_state_nxt = DRAIN;
`endif
            end
            RD_M1: begin
                s_arvalid  = m1_arvalid && !r_ar_done;
                m1_arready = s_arready && !r_ar_done;
                m1_rvalid  = s_rvalid || w_to_active;
                s_rready   = m1_rready && !w_to_active;
                if (w_r_hs) w_state_nxt = IDLE;
`ifdef AXI_ARB_TIMEOUT_EN
                if (w_to_acc) w_state_nxt = DRAIN;
`endif
            end
            WR_M1: begin
                s_awvalid  = m1_awvalid && !r_aw_done;
                m1_awready = s_awready && !r_aw_done;
                s_wvalid   = m1_wvalid && !r_w_done;
                m1_wready  = s_wready && !r_w_done;
                m1_bvalid  = s_bvalid || w_to_active;
                s_bready   = m1_bready && !w_to_active;
                if (w_b_hs) w_state_nxt = IDLE;
`ifdef AXI_ARB_TIMEOUT_EN
                if (w_to_acc) w_state_nxt = DRAIN;
`endif
            end
`ifdef AXI_ARB_TIMEOUT_EN
            DRAIN: begin
                // Swallow the late slave response; the master already got its error
                s_rready = 1'b1;
                s_bready = 1'b1;
                if (s_rvalid || s_bvalid) w_state_nxt = IDLE;
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    assign s_raddr  = w_rd_m1 ? m1_raddr : m0_raddr;
    assign s_waddr  = m1_waddr;
    assign s_wdata  = m1_wdata;
    assign s_wstrob = m1_wstrob;

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_rresp = w_to_active ? RESP_DECERR : s_rresp;
    assign m1_rresp = w_to_active ? RESP_DECERR : s_rresp;
    assign m1_bresp = w_to_active ? RESP_DECERR : s_bresp;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// =============================================================================
// tb_axi_lite_arbiter : directed self-checking bench for axi_lite_arbiter
// Revision: 1.0
// =============================================================================
module tb_axi_lite_arbiter;
    import axi_arb_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        m0_arvalid, m0_rready;
    logic [31:0] m0_raddr;
    logic        m0_arready, m0_rvalid;
    logic [31:0] m0_rdata;
    logic [2:0]  m0_rresp;
    logic        m1_arvalid, m1_awvalid, m1_wvalid, m1_rready, m1_bready;
    logic [31:0] m1_raddr, m1_waddr, m1_wdata;
    logic [3:0]  m1_wstrob;
    logic        m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid;
    logic [31:0] m1_rdata;
    logic [2:0]  m1_rresp, m1_bresp;
    logic        s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready;
    logic [31:0] s_raddr, s_waddr, s_wdata;
    logic [3:0]  s_wstrob;
    logic        s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
    logic [31:0] s_rdata;
    logic [2:0]  s_rresp, s_bresp;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    axi_lite_arbiter #(
        .DATA_LEN (32), .ADDR_LEN (32), .STROB_LEN (4), .TIMEOUT_CYC (8)
    ) dut (
        .sys_clk (sys_clk), .sys_rst_n (sys_rst_n),
        .m0_arvalid (m0_arvalid), .m0_rready (m0_rready), .m0_raddr (m0_raddr),
        .m0_arready (m0_arready), .m0_rvalid (m0_rvalid), .m0_rdata (m0_rdata),
        .m0_rresp (m0_rresp),
        .m1_arvalid (m1_arvalid), .m1_awvalid (m1_awvalid), .m1_wvalid (m1_wvalid),
        .m1_rready (m1_rready), .m1_bready (m1_bready), .m1_raddr (m1_raddr),
        .m1_waddr (m1_waddr), .m1_wdata (m1_wdata), .m1_wstrob (m1_wstrob),
        .m1_arready (m1_arready), .m1_awready (m1_awready), .m1_wready (m1_wready),
        .m1_rvalid (m1_rvalid), .m1_bvalid (m1_bvalid), .m1_rdata (m1_rdata),
        .m1_rresp (m1_rresp), .m1_bresp (m1_bresp),
        .s_arvalid (s_arvalid), .s_awvalid (s_awvalid), .s_wvalid (s_wvalid),
        .s_rready (s_rready), .s_bready (s_bready), .s_raddr (s_raddr),
        .s_waddr (s_waddr), .s_wdata (s_wdata), .s_wstrob (s_wstrob),
        .s_arready (s_arready), .s_awready (s_awready), .s_wready (s_wready),
        .s_rvalid (s_rvalid), .s_bvalid (s_bvalid), .s_rdata (s_rdata),
        .s_rresp (s_rresp), .s_bresp (s_bresp)
    );

    // Inputs change 2 time units after the rising edge; checks follow #1 later
    task automatic cyc();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic idle_inputs();
        m0_arvalid = 0; m0_rready = 0; m0_raddr = '0;
        m1_arvalid = 0; m1_awvalid = 0; m1_wvalid = 0; m1_rready = 0; m1_bready = 0;
        m1_raddr = '0; m1_waddr = '0; m1_wdata = '0; m1_wstrob = '0;
        s_arready = 0; s_awready = 0; s_wready = 0; s_rvalid = 0; s_bvalid = 0;
        s_rdata = '0; s_rresp = '0; s_bresp = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        sys_rst_n = 0;
        cyc(); cyc();
        sys_rst_n = 1;
        cyc();
    endtask

    task automatic test_reset();
        idle_inputs();
        sys_rst_n = 0;
        m0_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1; s_arready = 1; s_awready = 1;
        s_wready = 1; s_rvalid = 1; s_bvalid = 1; m0_rready = 1; m1_bready = 1;
        cyc(); cyc(); #1;
        n_assert++;
        if ({m0_arready, m0_rvalid, m1_arready, m1_awready, m1_wready, m1_rvalid, m1_bvalid,
             s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b %b %b %b %b %b %b %b %b %b %b %b expected all 0",
                     m0_arready, m0_rvalid, m1_arready, m1_awready, m1_wready, m1_rvalid,
                     m1_bvalid, s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready);
        end
        idle_inputs();
        cyc();
        sys_rst_n = 1;
        cyc();
    endtask

    task automatic test_m0_read();
        m0_arvalid = 1; m0_raddr = 32'h8000_0000; s_arready = 1; #1;
        n_assert++;
        if ({m0_arready, s_arvalid} !== 2'b00) begin
            n_fail++; $display("FAIL m0_idle_no_ready: got %b expected 00", {m0_arready, s_arvalid});
        end
        cyc(); #1;
        n_assert++;
        if ({s_arvalid, m0_arready, m1_arready} !== 3'b110 || s_raddr !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL m0_ar_grant: got %b addr %h expected 110 addr 80000000",
                     {s_arvalid, m0_arready, m1_arready}, s_raddr);
        end
        cyc(); m0_arvalid = 0; #1;
        n_assert++;
        if ({s_arvalid, m0_arready, m0_rvalid} !== 3'b000) begin
            n_fail++; $display("FAIL m0_ar_once: got %b expected 000", {s_arvalid, m0_arready, m0_rvalid});
        end
        cyc(); s_rvalid = 1; s_rdata = 32'h0000_0413; s_rresp = 3'b000; m0_rready = 1; #1;
        n_assert++;
        if ({m0_rvalid, s_rready, m1_rvalid, m1_bvalid} !== 4'b1100 || m0_rdata !== 32'h0000_0413
            || m0_rresp !== RESP_OKAY) begin
            n_fail++;
            $display("FAIL m0_r_data: got %b data %h resp %b expected 1100 data 00000413 resp 000",
                     {m0_rvalid, s_rready, m1_rvalid, m1_bvalid}, m0_rdata, m0_rresp);
        end
        cyc(); idle_inputs(); s_rvalid = 1; #1;
        n_assert++;
        if ({m0_rvalid, s_rready} !== 2'b00) begin
            n_fail++; $display("FAIL m0_back_idle: got %b expected 00", {m0_rvalid, s_rready});
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_tie();
        do_reset();
        m0_arvalid = 1; m1_arvalid = 1; m0_raddr = 32'h100; m1_raddr = 32'h200; s_arready = 1;
        cyc(); #1;
        n_assert++;
        if ({m0_arready, m1_arready} !== 2'b10 || s_raddr !== 32'h100) begin
            n_fail++;
            $display("FAIL tie_first_m0: got %b addr %h expected 10 addr 00000100",
                     {m0_arready, m1_arready}, s_raddr);
        end
        cyc(); m0_arvalid = 0; s_rvalid = 1; m0_rready = 1; #1;
        n_assert++;
        if ({m0_rvalid, m1_arready, m1_rvalid} !== 3'b100) begin
            n_fail++; $display("FAIL tie_m0_r: got %b expected 100", {m0_rvalid, m1_arready, m1_rvalid});
        end
        cyc(); s_rvalid = 0; m0_rready = 0; #1;
        n_assert++;
        if ({m0_arready, m1_arready, s_arvalid} !== 3'b000) begin
            n_fail++; $display("FAIL tie_gap_idle: got %b expected 000", {m0_arready, m1_arready, s_arvalid});
        end
        cyc(); #1;
        n_assert++;
        if ({m1_arready, s_arvalid, m0_arready} !== 3'b110 || s_raddr !== 32'h200) begin
            n_fail++;
            $display("FAIL tie_m1_n_plus_2: got %b addr %h expected 110 addr 00000200",
                     {m1_arready, s_arvalid, m0_arready}, s_raddr);
        end
        cyc(); m1_arvalid = 0; s_rvalid = 1; s_rdata = 32'h0000_CAFE; m1_rready = 1; #1;
        n_assert++;
        if ({m1_rvalid, m0_rvalid} !== 2'b10 || m1_rdata !== 32'h0000_CAFE) begin
            n_fail++;
            $display("FAIL tie_m1_r: got %b data %h expected 10 data 0000cafe", {m1_rvalid, m0_rvalid}, m1_rdata);
        end
        cyc(); s_rvalid = 0; m1_rready = 0; m0_arvalid = 1; m1_arvalid = 1;
        cyc(); #1;
        n_assert++;
        if ({m0_arready, m1_arready} !== 2'b10) begin
            n_fail++; $display("FAIL tie_second_m0: got %b expected 10", {m0_arready, m1_arready});
        end
        cyc(); m0_arvalid = 0; s_rvalid = 1; m0_rready = 1;
        cyc(); s_rvalid = 0; m0_rready = 0;
        cyc(); m1_arvalid = 0; s_rvalid = 1; m1_rready = 1;
        cyc(); idle_inputs();
        cyc();
    endtask

    task automatic test_write();
        m1_awvalid = 1; m1_waddr = 32'h8000_0100; m1_wdata = 32'hDEAD_BEEF; m1_wstrob = 4'b0011;
        s_awready = 1; s_wready = 1;
        cyc(); #1;
        n_assert++;
        if ({s_awvalid, m1_awready, s_wvalid, m1_wready, s_waddr} !== {4'b1101, 32'h8000_0100}) begin
            n_fail++;
            $display("FAIL wr_aw: got %b addr %h expected 1101 addr 80000100",
                     {s_awvalid, m1_awready, s_wvalid, m1_wready}, s_waddr);
        end
        cyc(); m1_awvalid = 0; #1;
        cyc(); m1_awvalid = 1; #1;
        n_assert++;
        if ({s_awvalid, m1_awready} !== 2'b00) begin
            n_fail++; $display("FAIL wr_aw_once: got %b expected 00", {s_awvalid, m1_awready});
        end
        m1_awvalid = 0;
        cyc(); m1_wvalid = 1; #1;
        n_assert++;
        if ({s_wvalid, m1_wready} !== 2'b11 || s_wdata !== 32'hDEAD_BEEF || s_wstrob !== 4'b0011) begin
            n_fail++;
            $display("FAIL wr_w_payload: got %b data %h strb %b expected 11 data deadbeef strb 0011",
                     {s_wvalid, m1_wready}, s_wdata, s_wstrob);
        end
        cyc(); s_bvalid = 1; s_bresp = 3'b000; m1_bready = 1; #1;
        n_assert++;
        if ({s_wvalid, m1_wready, m1_bvalid, s_bready, m0_rvalid, m1_rvalid} !== 6'b001100
            || m1_bresp !== RESP_OKAY) begin
            n_fail++;
            $display("FAIL wr_b: got %b resp %b expected 001100 resp 000",
                     {s_wvalid, m1_wready, m1_bvalid, s_bready, m0_rvalid, m1_rvalid}, m1_bresp);
        end
        cyc(); m1_wvalid = 0; #1;
        n_assert++;
        if ({m1_bvalid, s_bready} !== 2'b00) begin
            n_fail++; $display("FAIL wr_back_idle: got %b expected 00", {m1_bvalid, s_bready});
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_wr_before_rd();
        int rd_seen = 0;
        m1_awvalid = 1; m1_arvalid = 1; m1_wvalid = 1; m1_raddr = 32'h8000_0040;
        s_awready = 1; s_wready = 1; s_arready = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin #1; if ({s_awvalid, s_wvalid} !== 2'b11) rd_seen += 10; end
            if (i == 2) begin m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1; m1_bready = 1; end
            if (i == 3) begin s_bvalid = 0; m1_bready = 0; end
            #1;
            if (s_arvalid !== 1'b0 || m1_arready !== 1'b0) rd_seen++;
            cyc();
        end
        n_assert++;
        if (rd_seen != 0) begin
            n_fail++; $display("FAIL wr_first_order: got %0d violations expected 0", rd_seen);
        end
        #1;
        n_assert++;
        if ({s_arvalid, m1_arready} !== 2'b11 || s_raddr !== 32'h8000_0040) begin
            n_fail++;
            $display("FAIL wr_then_rd: got %b addr %h expected 11 addr 80000040", {s_arvalid, m1_arready}, s_raddr);
        end
        cyc(); m1_arvalid = 0; s_rvalid = 1; m1_rready = 1;
        cyc(); idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid();
        m1_arvalid = 1; m1_raddr = 32'h44; s_arready = 1;
        cyc();
        cyc(); m1_arvalid = 0; s_rvalid = 1; m1_rready = 1; #1;
        n_assert++;
        if ({m1_rvalid, s_rready} !== 2'b11) begin
            n_fail++; $display("FAIL mid_pre_reset: got %b expected 11", {m1_rvalid, s_rready});
        end
        sys_rst_n = 0; #1;
        n_assert++;
        if ({m1_rvalid, s_rready, m1_arready, s_arvalid, m0_arready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %b expected 00000",
                     {m1_rvalid, s_rready, m1_arready, s_arvalid, m0_arready});
        end
        idle_inputs();
        cyc(); cyc();
        sys_rst_n = 1;
        cyc(); m0_arvalid = 1; m0_raddr = 32'h8000_0200; s_arready = 1;
        cyc(); #1;
        n_assert++;
        if ({m0_arready, s_arvalid, m1_rvalid} !== 3'b110 || s_raddr !== 32'h8000_0200) begin
            n_fail++;
            $display("FAIL mid_after_reset: got %b addr %h expected 110 addr 80000200",
                     {m0_arready, s_arvalid, m1_rvalid}, s_raddr);
        end
        cyc(); m0_arvalid = 0; s_rvalid = 1; m0_rready = 1;
        cyc(); idle_inputs();
        cyc();
    endtask

`ifdef AXI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        do_reset();
        m1_arvalid = 1; m1_raddr = 32'h8000_0300; s_arready = 1;
        cyc();
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 1) m1_arvalid = 0;
            #1;
            if (m1_rvalid !== 1'b0) early++;
        end
        n_assert++;
        if (early != 0) begin
            n_fail++; $display("FAIL to_early: got %0d early rvalid cycles expected 0", early);
        end
        cyc(); m1_rready = 1; #1;
        n_assert++;
        if ({m1_rvalid, s_rready} !== 2'b10 || m1_rresp !== RESP_DECERR) begin
            n_fail++;
            $display("FAIL to_resp: got %b resp %b expected 10 resp 011", {m1_rvalid, s_rready}, m1_rresp);
        end
        cyc(); m1_rready = 0; #1;
        n_assert++;
        if ({m1_rvalid, s_rready} !== 2'b01) begin
            n_fail++; $display("FAIL to_drain: got %b expected 01", {m1_rvalid, s_rready});
        end
        cyc(); s_rvalid = 1; #1;
        n_assert++;
        if ({m1_rvalid, s_rready} !== 2'b01) begin
            n_fail++; $display("FAIL to_discard: got %b expected 01", {m1_rvalid, s_rready});
        end
        cyc(); s_rvalid = 0; #1;
        n_assert++;
        if ({m1_rvalid, s_rready, s_bready} !== 3'b000) begin
            n_fail++; $display("FAIL to_idle: got %b expected 000", {m1_rvalid, s_rready, s_bready});
        end
        idle_inputs();
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_m0_read();
        test_tie();
        test_write();
        test_wr_before_rd();
        test_reset_mid();
`ifdef AXI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
